// File: rtl/rr_stream_mux.sv
// Round-robin N-channel valid/ready stream mux with one registered output stage.
// Define RRMUX_PKT_LOCK_EN to hold the grant for a whole packet (until in_last).
module rr_stream_mux #(
    parameter int WIDTH = 32,
    parameter int CH    = 4,
    localparam int SW   = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [CH*WIDTH-1:0]   in_data,
    input  logic [CH-1:0]         in_valid,
    input  logic [CH-1:0]         in_last,
    output logic [CH-1:0]         in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [SW-1:0]         out_sel,
    input  logic                  out_ready
);

    logic [SW-1:0]    ptr_q, ptr_d;
    logic [SW-1:0]    scan_idx;
    logic [SW-1:0]    cand;
    logic             scan_vld;
    logic [SW-1:0]    sel;
    logic             sel_vld;
    logic             sel_last;
    logic [WIDTH-1:0] sel_data;
    logic             load;
    logic             xfer;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [SW-1:0]    out_sel_q, out_sel_d;

    // Scan from ptr+CH down to ptr+1 so the nearest valid channel after ptr wins last.
    always_comb begin
        scan_vld = 1'b0;
        scan_idx = '0;
        cand     = '0;
        for (int k = CH; k >= 1; k--) begin
            cand = SW'((int'(ptr_q) + k) % CH);
            if (in_valid[cand]) begin
                scan_vld = 1'b1;
                scan_idx = cand;
            end
        end
    end

`ifdef RRMUX_PKT_LOCK_EN
    typedef enum logic {IDLE, LOCK} state_e;
    state_e        state_q, state_d;
    logic [SW-1:0] cur_q, cur_d;

    assign sel     = (state_q == LOCK) ? cur_q : scan_idx;
    assign sel_vld = (state_q == LOCK) | scan_vld;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (sel_last) begin
                        ptr_d = sel;
                    end else begin
                        state_d = LOCK;
                        cur_d   = sel;
                    end
                end
            end
            LOCK: begin
                if (xfer && sel_last) begin
                    state_d = IDLE;
                    ptr_d   = cur_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
        end
    end
`else
    assign sel     = scan_idx;
    assign sel_vld = scan_vld;

    // Without packet lock every beat is its own arbitration round.
    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = sel;
        end
    end
`endif

    assign load     = out_ready | ~out_valid_q;
    assign sel_data = in_data[int'(sel)*WIDTH +: WIDTH];
    assign sel_last = in_last[sel];
    assign xfer     = rstn & load & sel_vld & in_valid[sel];

    // in_ready is gated by rstn so nothing is offered while reset is held.
    always_comb begin
        in_ready = '0;
        if (rstn && load && sel_vld) begin
            in_ready[sel] = 1'b1;
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;
        if (load) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = sel_data;
                out_last_d = sel_last;
                out_sel_d  = sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q       <= SW'(CH - 1);
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;

endmodule
